// File: rtl/matrix_coproc_pkg.sv
// Shared definitions for the matrix coprocessor sequencer: opcodes, FSM states
// and the opcode classification helpers used by the decoder.
// No ports; imported by matrix_coproc_ctrl and its memory stepper.
package matrix_coproc_pkg;

  localparam logic [3:0] OP_READ   = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_SUM    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_MUL    = 4'd5;
  localparam logic [3:0] OP_TRANSP = 4'd6;
  localparam logic [3:0] OP_OPST   = 4'd7;
  localparam logic [3:0] OP_MULSCL = 4'd8;
  localparam logic [3:0] OP_DET2   = 4'd9;
  localparam logic [3:0] OP_DET3   = 4'd10;
  localparam logic [3:0] OP_DET4   = 4'd11;
  localparam logic [3:0] OP_DET5   = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MEM, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE_C, S_RESP
  } state_t;

  // DETk only makes sense when the matrix is at least k x k.
  function automatic logic is_illegal(input logic [3:0] op, input int n);
    case (op)
      OP_READ, OP_WRITE, OP_SUM, OP_SUB, OP_MUL,
      OP_TRANSP, OP_OPST, OP_MULSCL, OP_DET2: return 1'b0;
      OP_DET3: return n < 3;
      OP_DET4: return n < 4;
      OP_DET5: return n < 5;
      default: return 1'b1;
    endcase
  endfunction

  // Unary ops only need matrix A.
  function automatic logic is_unary(input logic [3:0] op);
    return (op >= OP_TRANSP) && (op <= OP_DET5);
  endfunction

  // Determinants produce a single scalar in element 0.
  function automatic logic is_det(input logic [3:0] op);
    return (op >= OP_DET2) && (op <= OP_DET5);
  endfunction

endpackage

// File: rtl/matrix_coproc_ctrl_mem_seq.sv
// Memory stepper: issues one request per element at base+idx, advances idx on each ack.
// Latency: first request the cycle after start; 2 cycles per element with a 1-cycle ack.
// Backpressure: each request waits for mem_done; never more than one outstanding.
// Ports: start/base/last_idx/wr load a new run (start wins over an ack in the same
// cycle); mem_start/mem_wr/mem_addr/mem_done form the memory handshake;
// idx is the element in flight, ack marks its completion, last marks the final ack.
module matrix_coproc_ctrl_mem_seq #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic              wr,
  input  logic              mem_done,
  output logic              mem_start,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [IDX_W-1:0]  idx,
  output logic              ack,
  output logic              last
);

  logic              active_q;
  logic              pend_q;
  logic              wr_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  last_q;
  logic [IDX_W-1:0]  idx_q;

  assign mem_start = active_q & ~pend_q;
  assign mem_wr    = mem_start & wr_q;
  // Address is base+idx truncated to the bus width.
  assign mem_addr  = mem_start ? base_q + ADDR_W'(idx_q) : '0;
  assign idx       = idx_q;
  // An ack only counts while a request is actually outstanding.
  assign ack       = pend_q & mem_done;
  assign last      = ack & (idx_q == last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      pend_q   <= 1'b0;
      wr_q     <= 1'b0;
      base_q   <= '0;
      last_q   <= '0;
      idx_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      pend_q   <= 1'b0;
      wr_q     <= wr;
      base_q   <= base;
      last_q   <= last_idx;
      idx_q    <= '0;
    end else begin
      if (mem_start) pend_q <= 1'b1;
      if (ack) begin
        pend_q <= 1'b0;
        if (last) begin
          active_q <= 1'b0;
          idx_q    <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/matrix_coproc_ctrl.sv
// Matrix coprocessor instruction sequencer: single-word READ/WRITE, and for
// arithmetic ops load A (and B), run the ALU, store C.
// Latency: READ/WRITE 4 cycles accept->done with 1-cycle ack; arithmetic
// 1 + 2E (A) + 2E (B, binary only) + ALU + 2E (C; 2 for DET) + 1.
// Backpressure: instr_ready only in IDLE; one memory request outstanding.
// Ports: instruction/instr_valid/instr_ready in; busy/done/error/rd_data status;
// mem_* single-word memory handshake; alu_* plus matrix_a/b/c towards the ALU.
module matrix_coproc_ctrl
  import matrix_coproc_pkg::*;
#(
  parameter int N      = 5,
  parameter int ELEM_W = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int BASE_A = 0,
  parameter int BASE_B = 32,
  parameter int BASE_C = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_start,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_done,
  output logic                  alu_start,
  output logic [3:0]            alu_opcode,
  output logic [15:0]           alu_scalar,
  output logic [N*N*ELEM_W-1:0] matrix_a,
  output logic [N*N*ELEM_W-1:0] matrix_b,
  input  logic [N*N*ELEM_W-1:0] matrix_c,
  input  logic                  alu_done
);

  localparam int E     = N * N;
  localparam int IDX_W = $clog2(E);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(E - 1);

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         data_q;
  logic                err_q;
  logic                alu_pend_q;
  logic [E*ELEM_W-1:0] c_q;

  logic                seq_start, seq_wr, seq_ack, seq_last;
  logic [ADDR_W-1:0]   seq_base;
  logic [IDX_W-1:0]    seq_last_idx, seq_idx;
  logic [ELEM_W-1:0]   c_elem;
  logic                unused_instr;

  assign unused_instr = ^instruction;
  assign alu_opcode   = op_q;
  assign alu_scalar   = data_q;
  assign c_elem       = c_q[int'(seq_idx)*ELEM_W +: ELEM_W];
  assign mem_wdata    = !mem_start          ? '0 :
                        (state_q == S_MEM)  ? DATA_W'(data_q) : DATA_W'(c_elem);

  matrix_coproc_ctrl_mem_seq #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start),
    .base     (seq_base),
    .last_idx (seq_last_idx),
    .wr       (seq_wr),
    .mem_done (mem_done),
    .mem_start(mem_start),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .idx      (seq_idx),
    .ack      (seq_ack),
    .last     (seq_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    alu_start    = 1'b0;
    seq_start    = 1'b0;
    seq_wr       = 1'b0;
    seq_base     = '0;
    seq_last_idx = '0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_illegal(op_q, N)) begin
          state_d = S_RESP;
        end else if (op_q == OP_READ || op_q == OP_WRITE) begin
          seq_start = 1'b1;
          seq_base  = addr_q;
          seq_wr    = (op_q == OP_WRITE);
          state_d   = S_MEM;
        end else begin
          seq_start    = 1'b1;
          seq_base     = ADDR_W'(BASE_A);
          seq_last_idx = LAST_IDX;
          state_d      = S_LOAD_A;
        end
      end
      S_MEM: if (seq_last) state_d = S_RESP;
      S_LOAD_A: begin
        if (seq_last) begin
          if (is_unary(op_q)) begin
            state_d = S_EXEC;
          end else begin
            // Chain straight into B so its first request issues next cycle.
            seq_start    = 1'b1;
            seq_base     = ADDR_W'(BASE_B);
            seq_last_idx = LAST_IDX;
            state_d      = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: if (seq_last) state_d = S_EXEC;
      S_EXEC: begin
        alu_start = ~alu_pend_q;
        if (alu_pend_q && alu_done) begin
          seq_start    = 1'b1;
          seq_base     = ADDR_W'(BASE_C);
          seq_wr       = 1'b1;
          seq_last_idx = is_det(op_q) ? '0 : LAST_IDX;
          state_d      = S_STORE_C;
        end
      end
      S_STORE_C: if (seq_last) state_d = S_RESP;
      S_RESP: begin
        done    = 1'b1;
        error   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      alu_pend_q <= 1'b0;
      c_q        <= '0;
      rd_data    <= '0;
      matrix_a   <= '0;
      matrix_b   <= '0;
    end else begin
      if (state_q == S_IDLE && instr_valid) begin
        op_q   <= instruction[3:0];
        addr_q <= instruction[ADDR_W+3:4];
        data_q <= instruction[31:16];
      end
      if (state_q == S_DECODE) err_q <= is_illegal(op_q, N);
      if (seq_ack) begin
        case (state_q)
          S_MEM:    if (op_q == OP_READ) rd_data <= mem_rdata;
          S_LOAD_A: matrix_a[int'(seq_idx)*ELEM_W +: ELEM_W] <= mem_rdata[ELEM_W-1:0];
          S_LOAD_B: matrix_b[int'(seq_idx)*ELEM_W +: ELEM_W] <= mem_rdata[ELEM_W-1:0];
          default: ;
        endcase
      end
      if (alu_start) begin
        alu_pend_q <= 1'b1;
      end else if (state_q == S_EXEC && alu_pend_q && alu_done) begin
        alu_pend_q <= 1'b0;
        c_q        <= matrix_c;
      end
    end
  end

endmodule
